csa_scheduler: RTL and testbench

Shared-adder scheduler that time-multiplexes one 4-bit `carry_select_adder` between two requesters. Each accepted request is a WIDTH-bit addition, executed nibble-serially with the carry registered between nibbles. It sits between two client blocks and the existing adder datapath, owning arbitration, operand sequencing and result hand-off.

---
 rtl/csa_sched_pkg.sv | 13 +
 rtl/carry_select_adder.sv | 24 ++
 rtl/csa_scheduler.sv | 150 +++++++++++++++
 tb/tb_csa_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/csa_sched_pkg.sv
// Shared definitions for the nibble-serial shared-adder scheduler.
// State encoding plus the nibble width that the adder datapath works in.
package csa_sched_pkg;

    localparam int NIBW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/carry_select_adder.sv
// 4-bit carry-select adder: low pair ripples, high pair is precomputed for
// both carry values and picked by the low-pair carry.
module carry_select_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;

    // Both high-pair candidates are formed in parallel with the low pair.
    always_comb begin
        lo   = {1'b0, A[1:0]} + {1'b0, B[1:0]} + {2'b00, cin};
        hi0  = {1'b0, A[3:2]} + {1'b0, B[3:2]};
        hi1  = {1'b0, A[3:2]} + {1'b0, B[3:2]} + 3'd1;
        sum  = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
        cout = lo[2] ? hi1[2] : hi0[2];
    end

endmodule

// File: rtl/csa_scheduler.sv
// Two-requester scheduler around one 4-bit carry_select_adder. A granted
// WIDTH-bit add runs one nibble per cycle with the carry registered between
// nibbles; the result is held until the consumer takes it.
// Optional macro CSA_SCHED_SUB_EN adds per-requester subtract (a - b).
module csa_scheduler
    import csa_sched_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
`ifdef CSA_SCHED_SUB_EN
    input  logic             req0_sub,
    input  logic             req1_sub,
`endif
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
);

    localparam int NIB   = WIDTH / NIBW;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               last_grant_q, last_grant_d;
    logic               id_q, id_d;
    logic               sub_q, sub_d;
    logic               grant;
    logic [NIBW-1:0]    add_a, add_b, add_sum;
    logic               add_cout;
    logic               sub0, sub1;

`ifdef CSA_SCHED_SUB_EN
    assign sub0 = req0_sub;
    assign sub1 = req1_sub;
`else
    assign sub0 = 1'b0;
    assign sub1 = 1'b0;
`endif

    // Operand nibble selection; subtract feeds the inverted B nibble.
    always_comb begin
        add_a = a_q[idx_q*NIBW +: NIBW];
        add_b = b_q[idx_q*NIBW +: NIBW] ^ {NIBW{sub_q}};
    end

    carry_select_adder u_adder (
        .A    (add_a),
        .B    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Arbitration, sequencing and result hand-off.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        idx_d        = idx_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        sub_d        = sub_q;

        // A lone requester wins; a tie goes to whoever was not served last.
        if (req0_valid && req1_valid) grant = ~last_grant_q;
        else if (req0_valid)          grant = 1'b0;
        else if (req1_valid)          grant = 1'b1;
        else                          grant = ~last_grant_q;

        req0_ready = (state_q == IDLE) && (grant == 1'b0) && !rst;
        req1_ready = (state_q == IDLE) && (grant == 1'b1) && !rst;

        res_valid = (state_q == DONE);
        res_sum   = (state_q == DONE) ? sum_q : '0;
        res_cout  = (state_q == DONE) ? carry_q : 1'b0;
        res_id    = (state_q == DONE) ? id_q : 1'b0;

        case (state_q)
            IDLE: begin
                if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                    a_d          = grant ? req1_a : req0_a;
                    b_d          = grant ? req1_b : req0_b;
                    sub_d        = grant ? sub1 : sub0;
                    carry_d      = (grant ? sub1 : sub0) ? 1'b1 : (grant ? req1_cin : req0_cin);
                    idx_d        = '0;
                    id_d         = grant;
                    last_grant_d = grant;
                    state_d      = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*NIBW +: NIBW] = add_sum;
                carry_d = add_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIB - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            sub_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            idx_q        <= idx_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            sub_q        <= sub_d;
        end
    end

endmodule

// File: tb/tb_csa_scheduler.sv
// Self-checking bench for csa_scheduler (WIDTH=16): directed table,
// hand sequences for reset/backpressure, and randomized transactions
// checked against an arithmetic model.
module tb_csa_scheduler;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_cin, req1_cin, req0_sub, req1_sub;
    logic         res_valid, res_ready, res_cout, res_id;
    logic [W-1:0] res_sum;

    int n_chk  = 0;
    int n_pass = 0;
    bit lg;  // model of the last granted requester

    always #5 clk = ~clk;

    csa_scheduler #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
`ifdef CSA_SCHED_SUB_EN
        .req0_sub   (req0_sub),
        .req1_sub   (req1_sub),
`endif
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id)
    );

    typedef struct {
        bit       v0, v1;
        bit [15:0] a0, b0, a1, b1;
        bit       c0, c1, s0, s1;
        int       stall;
        bit [15:0] es;
        bit       ec, eid;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain-arithmetic sum (or difference) with carry-out.
    function automatic bit [16:0] model(input bit [15:0] a, b, input bit c, s);
        if (s) return {1'b0, a} + {1'b0, ~b} + 17'd1;
        return {1'b0, a} + {1'b0, b} + {16'd0, c};
    endfunction

    // One full transaction starting from IDLE; returns after DONE->IDLE.
    task automatic do_txn(input vec_t v);
        bit [15:0] hs;
        int        n;
        res_ready  = 1'b0;
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_cin = v.c0; req0_sub = v.s0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_cin = v.c1; req1_sub = v.s1;
        #1;
        chk("grant_rdy0", req0_ready, v.eid == 1'b0);
        chk("grant_rdy1", req1_ready, v.eid == 1'b1);
        tick();  // accept edge
        lg = v.eid;
        // operands wiggle after acceptance and must not matter
        req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom);
        req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom);
        req0_sub = 1'($urandom); req1_sub = 1'($urandom);
        #1;
        chk("busy_rdy", {req0_ready, req1_ready}, 2'b00);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("early_valid", res_valid, 1'b0);
        end
        tick();
        chk("latency_valid", res_valid, 1'b1);
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        if (!res_valid) return;
        chk("sum", res_sum, v.es);
        chk("cout", res_cout, v.ec);
        chk("id", res_id, v.eid);
        hs = res_sum;
        for (int k = 0; k < v.stall; k++) begin
            tick();
            chk("hold_valid", res_valid, 1'b1);
            chk("hold_sum", res_sum, hs);
            chk("hold_rdy", {req0_ready, req1_ready}, 2'b00);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("released", res_valid, 1'b0);
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        // contention: 0,1,0,1 then backpressure on the fourth
        tbl[0] = '{1,1, 16'h0001,16'h0002, 16'h8000,16'h8000, 0,1, 0,0, 0, 16'h0003,0,0};
        tbl[1] = '{1,1, 16'h0001,16'h0002, 16'h8000,16'h8000, 0,1, 0,0, 0, 16'h0001,1,1};
        tbl[2] = '{1,1, 16'h7FFF,16'h0001, 16'hABCD,16'h1111, 1,0, 0,0, 0, 16'h8001,0,0};
        tbl[3] = '{1,1, 16'h7FFF,16'h0001, 16'hABCD,16'h1111, 1,0, 0,0, 3, 16'hBCDE,0,1};
        tbl[4] = '{1,0, 16'hFFFF,16'h0001, 16'h0000,16'h0000, 0,0, 0,0, 0, 16'h0000,1,0};
        tbl[5] = '{0,1, 16'h0000,16'h0000, 16'h1234,16'h4321, 0,1, 0,0, 1, 16'h5556,0,1};
        tbl[6] = '{1,0, 16'h00FF,16'h0001, 16'h0000,16'h0000, 0,0, 0,0, 0, 16'h0100,0,0};

        rst = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_cin = 0; req1_cin = 0; req0_sub = 0; req1_sub = 0;
        tick(); tick();
        chk("rst_rdy", {req0_ready, req1_ready}, 2'b00);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_sum", res_sum, 16'h0000);
        chk("rst_cout", res_cout, 1'b0);
        rst = 1'b0;
        lg = 1'b1;

        for (int i = 0; i < 6; i++) do_txn(tbl[i]);

        // reset while idx==2: nothing must come out
        req1_valid = 1'b0; req0_valid = 1'b1;
        req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 0;
        tick();          // accept
        req0_valid = 1'b0;
        tick(); tick();  // idx now 2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lg = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rst_run_novalid", res_valid, 1'b0);
        end
        do_txn(tbl[6]);

`ifdef CSA_SCHED_SUB_EN
        rv = '{1,0, 16'h0005,16'h0007, 0,0, 0,0, 1,0, 0, 16'hFFFE,0,0};
        do_txn(rv);
        rv = '{1,0, 16'h0007,16'h0005, 0,0, 1,0, 1,0, 0, 16'h0002,1,0};
        do_txn(rv);
`endif

        // randomized transactions against the model
        for (int i = 0; i < 20; i++) begin
            bit [16:0] r;
            rv.v0 = 1'($urandom); rv.v1 = 1'($urandom);
            if (!rv.v0 && !rv.v1) rv.v0 = 1'b1;
            rv.a0 = 16'($urandom); rv.b0 = 16'($urandom); rv.c0 = 1'($urandom);
            rv.a1 = 16'($urandom); rv.b1 = 16'($urandom); rv.c1 = 1'($urandom);
`ifdef CSA_SCHED_SUB_EN
            rv.s0 = 1'($urandom); rv.s1 = 1'($urandom);
`else
            rv.s0 = 1'b0; rv.s1 = 1'b0;
`endif
            rv.stall = int'($urandom_range(0, 2));
            rv.eid = (rv.v0 && rv.v1) ? ~lg : rv.v1;
            r = rv.eid ? model(rv.a1, rv.b1, rv.c1, rv.s1) : model(rv.a0, rv.b0, rv.c0, rv.s0);
            rv.es = r[15:0];
            rv.ec = r[16];
            do_txn(rv);
        end

        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
